// File: rtl/multi_gate_delay_gen.sv
// N-channel gate/delay generator: one synchronised trigger starts a shared run
// counter, and each channel emits one gate pulse with its own delay, width, enable and polarity.
module multi_gate_delay_gen #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int TCNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_trigger,
  input  logic [N_CH*CNT_W-1:0]   i_delay,
  input  logic [N_CH*CNT_W-1:0]   i_width,
  input  logic [N_CH-1:0]         i_ch_en,
  input  logic [N_CH-1:0]         i_polarity,
  input  logic                    i_retrig,
  output logic [N_CH-1:0]         o_pulse,
  output logic                    o_busy,
  output logic                    o_missed,
  output logic [TCNT_W-1:0]       o_trig_cnt,
  output logic [TCNT_W-1:0]       o_miss_cnt
);

  localparam int RW = CNT_W + 1;

  logic                         sync1, sync2, last, evt;
  logic                         accept, ignore;
  logic [RW-1:0]                cnt, cnt_next, run_len, run_len_in;
  logic [N_CH-1:0]              active, active_next;
  logic [N_CH-1:0][CNT_W-1:0]   sh_delay, sh_width;
  logic [N_CH-1:0]              sh_en;

  // Longest enabled window; sums carry one extra bit so they never overflow.
  function automatic logic [RW-1:0] calc_run_len(
    input logic [N_CH*CNT_W-1:0] d,
    input logic [N_CH*CNT_W-1:0] w,
    input logic [N_CH-1:0]       en
  );
    logic [RW-1:0] best;
    logic [RW-1:0] sum;
    best = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, d[k*CNT_W +: CNT_W]} + {1'b0, w[k*CNT_W +: CNT_W]};
      if (en[k] && (w[k*CNT_W +: CNT_W] != '0) && (sum > best)) best = sum;
    end
    return best;
  endfunction

  function automatic logic win_hit(
    input logic [RW-1:0]    c,
    input logic [CNT_W-1:0] d,
    input logic [CNT_W-1:0] w
  );
    logic [RW-1:0] lo;
    logic [RW-1:0] hi;
    lo = {1'b0, d};
    hi = lo + {1'b0, w};
    return (c > lo) && (c <= hi);
  endfunction

  // Two-flop synchroniser plus last-state register; the event is one cycle wide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      last  <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync1 <= i_trigger;
      sync2 <= sync1;
      last  <= sync2;
      evt   <= sync2 & ~last;
    end
  end

  assign run_len_in = calc_run_len(i_delay, i_width, i_ch_en);
  assign accept     = evt && (!o_busy || i_retrig);
  assign ignore     = evt && o_busy && !i_retrig;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    cnt_next = '0;
    if (accept)                            cnt_next = (run_len_in == '0) ? '0 : RW'(1);
    else if (cnt == '0 || cnt == run_len)  cnt_next = '0;
    else                                   cnt_next = cnt + RW'(1);
  end

  always_comb begin
    active_next = '0;
    for (int k = 0; k < N_CH; k++)
      active_next[k] = sh_en[k] && win_hit(cnt, sh_delay[k], sh_width[k]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: shadow configuration is reset along with the control state so a run never sees stale values.
    if (i_rst) begin
      cnt        <= '0;
      run_len    <= '0;
      sh_delay   <= '0;
      sh_width   <= '0;
      sh_en      <= '0;
      active     <= '0;
      o_busy     <= 1'b0;
      o_missed   <= 1'b0;
      o_trig_cnt <= '0;
      o_miss_cnt <= '0;
    end else begin
      cnt      <= cnt_next;
      o_busy   <= (cnt_next != '0);
      active   <= active_next;
      o_missed <= ignore;
      if (accept) begin
        o_trig_cnt <= o_trig_cnt + TCNT_W'(1);
        sh_delay   <= i_delay;
        sh_width   <= i_width;
        sh_en      <= i_ch_en;
        run_len    <= run_len_in;
      end
      if (ignore) o_miss_cnt <= o_miss_cnt + TCNT_W'(1);
    end
  end

  // Polarity applies live so an idle output tracks the configured inactive level.
  assign o_pulse = active ^ i_polarity;

endmodule

// File: tb/tb_multi_gate_delay_gen.sv
// Bench for multi_gate_delay_gen: table-driven runs with a per-cycle scoreboard,
// plus hand sequences for async reset mid-gate and a narrow-counter boundary instance.
module tb_multi_gate_delay_gen;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 32;
  localparam int TCNT_W = 16;
  localparam int L      = 36;

  localparam logic [127:0] BASE_D = {32'd2, 32'd10, 32'd5, 32'd0};
  localparam logic [127:0] BASE_W = {32'd0, 32'd1, 32'd4, 32'd3};
  localparam logic [127:0] NEW_D  = {32'd2, 32'd10, 32'd1, 32'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, trigger, retrig;
  logic [N_CH*CNT_W-1:0]     delay, width;
  logic [N_CH-1:0]           ch_en, polarity, pulse;
  logic                      busy, missed;
  logic [TCNT_W-1:0]         trig_cnt, miss_cnt;

  logic       s_trigger, s_retrig, s_busy, s_missed;
  logic [7:0] s_delay, s_width;
  logic [0:0] s_en, s_pol, s_pulse;
  logic [3:0] s_trig_cnt, s_miss_cnt;

  multi_gate_delay_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .TCNT_W(TCNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_trigger(trigger),
    .i_delay(delay), .i_width(width), .i_ch_en(ch_en), .i_polarity(polarity),
    .i_retrig(retrig), .o_pulse(pulse), .o_busy(busy), .o_missed(missed),
    .o_trig_cnt(trig_cnt), .o_miss_cnt(miss_cnt)
  );

  multi_gate_delay_gen #(.N_CH(1), .CNT_W(8), .TCNT_W(4)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_trigger(s_trigger),
    .i_delay(s_delay), .i_width(s_width), .i_ch_en(s_en), .i_polarity(s_pol),
    .i_retrig(s_retrig), .o_pulse(s_pulse), .o_busy(s_busy), .o_missed(s_missed),
    .o_trig_cnt(s_trig_cnt), .o_miss_cnt(s_miss_cnt)
  );

  typedef struct {
    logic [N_CH-1:0][CNT_W-1:0] delay;
    logic [N_CH-1:0][CNT_W-1:0] width;
    logic [N_CH-1:0]            en;
    logic [N_CH-1:0]            pol;
    logic                       retrig;
    int                         gap;
    logic                       hold;
    int                         chg_at;
    logic [N_CH-1:0][CNT_W-1:0] chg_delay;
  } vec_t;

  typedef struct {
    int              e;
    logic [N_CH-1:0] pulse;
    logic            busy;
    logic            missed;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_trig = 0;
  int   exp_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] d, input logic [127:0] w,
                              input logic [3:0] en, input logic [3:0] pol,
                              input logic rt, input int gap, input logic hold,
                              input int chg_at, input logic [127:0] chg_d);
    vec_t v;
    v.delay = d;  v.width = w;  v.en = en;  v.pol = pol;  v.retrig = rt;
    v.gap = gap;  v.hold = hold;  v.chg_at = chg_at;  v.chg_delay = chg_d;
    return v;
  endfunction

  // Counter value after edge e, given accept edges a0/a1 (-1 = none) and run length.
  function automatic longint cnt_at(input int e, input int a0, input int a1, input longint rl);
    int a;
    longint n;
    if (a1 >= 0 && e >= a1)      a = a1;
    else if (a0 >= 0 && e >= a0) a = a0;
    else                         a = -1;
    if (a < 0) return 0;
    n = longint'(e - a + 1);
    return (n > rl) ? 0 : n;
  endfunction

  task automatic run_vec(input vec_t v, input int tag);
    longint rl, c, d, w;
    int     a0, a1, ign, n;
    logic   act;
    exp_t   x;
    rl = 0;
    for (int k = 0; k < N_CH; k++) begin
      d = longint'(v.delay[k]);
      w = longint'(v.width[k]);
      if (v.en[k] && w != 0 && d + w > rl) rl = d + w;
    end
    a0 = 3;  a1 = -1;  ign = -1;
    exp_trig++;
    if (v.gap > 0) begin
      if (v.retrig || cnt_at(v.gap + 2, a0, -1, rl) == 0) begin
        a1 = v.gap + 3;
        exp_trig++;
      end else begin
        ign = v.gap + 3;
        exp_miss++;
      end
    end
    for (int e = 0; e < L; e++) begin
      x.e = e;
      c = cnt_at(e - 1, a0, a1, rl);
      for (int k = 0; k < N_CH; k++) begin
        d = longint'(v.delay[k]);
        w = longint'(v.width[k]);
        act = v.en[k] && (c > d) && (c <= d + w);
        x.pulse[k] = act ^ v.pol[k];
      end
      x.busy   = (cnt_at(e, a0, a1, rl) != 0);
      x.missed = (e == ign);
      sb.push_back(x);
    end
    delay = v.delay;  width = v.width;  ch_en = v.en;  polarity = v.pol;
    retrig = v.retrig;  trigger = 1'b1;
    for (int e = 0; e < L; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        check($sformatf("v%0d e%0d scoreboard_empty", tag, e), 1, 0);
      end else begin
        x = sb.pop_front();
        check($sformatf("v%0d e%0d pulse", tag, x.e), pulse, x.pulse);
        check($sformatf("v%0d e%0d busy", tag, x.e), busy, x.busy);
        check($sformatf("v%0d e%0d missed", tag, x.e), missed, x.missed);
      end
      n = e + 1;
      trigger = v.hold || (n <= 1) || (v.gap > 0 && (n == v.gap || n == v.gap + 1));
      if (v.chg_at > 0 && n == v.chg_at) delay = v.chg_delay;
    end
    check($sformatf("v%0d trig_cnt", tag), trig_cnt, exp_trig);
    check($sformatf("v%0d miss_cnt", tag), miss_cnt, exp_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, np, pe;

    vecs[0] = mk(BASE_D, BASE_W, 4'b1111, 4'b0000, 1'b0, 0, 1'b0, 0, '0);
    vecs[1] = mk(BASE_D, BASE_W, 4'b1111, 4'b0000, 1'b0, 6, 1'b0, 0, '0);
    vecs[2] = mk(BASE_D, BASE_W, 4'b1111, 4'b0000, 1'b1, 6, 1'b0, 0, '0);
    vecs[3] = mk(BASE_D, BASE_W, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 0, '0);
    vecs[4] = mk(BASE_D, '0,     4'b1111, 4'b0000, 1'b0, 0, 1'b0, 0, '0);
    vecs[5] = mk(BASE_D, BASE_W, 4'b1111, 4'b1010, 1'b0, 0, 1'b0, 0, '0);
    vecs[6] = mk(BASE_D, BASE_W, 4'b1111, 4'b0000, 1'b0, 0, 1'b0, 5, NEW_D);
    vecs[7] = mk(NEW_D,  BASE_W, 4'b1111, 4'b0000, 1'b0, 0, 1'b0, 0, '0);
    vecs[8] = mk(BASE_D, BASE_W, 4'b1111, 4'b0011, 1'b0, 0, 1'b1, 0, '0);

    rst = 1'b1;  trigger = 1'b0;  retrig = 1'b0;
    delay = '0;  width = '0;  ch_en = '0;  polarity = 4'b0110;
    s_trigger = 1'b0;  s_retrig = 1'b0;  s_delay = '0;  s_width = '0;
    s_en = 1'b0;  s_pol = 1'b1;

    repeat (2) @(negedge clk);
    check("reset pulse", pulse, 4'b0110);
    check("reset busy", busy, 0);
    check("reset missed", missed, 0);
    check("reset trig_cnt", trig_cnt, 0);
    check("reset miss_cnt", miss_cnt, 0);
    check("reset small pulse", s_pulse, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
      trigger = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Asynchronous reset while ch0 is mid-gate, trigger held high across release.
    delay = BASE_D;  width = BASE_W;  ch_en = 4'b1111;  polarity = 4'b0011;
    retrig = 1'b0;  trigger = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("pre-reset mid-gate pulse", pulse, 4'b0010);
    rst = 1'b1;
    #1;
    check("async reset pulse", pulse, 4'b0011);
    check("async reset busy", busy, 0);
    check("async reset missed", missed, 0);
    check("async reset trig_cnt", trig_cnt, 0);
    check("async reset miss_cnt", miss_cnt, 0);
    exp_trig = 0;
    exp_miss = 0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[8], 8);
    trigger = 1'b0;
    repeat (4) @(negedge clk);

    // Narrow counter: delay = 2^8-1, width = 1 needs the extra counter bit.
    s_pol = 1'b0;  s_en = 1'b1;  s_delay = 8'd255;  s_width = 8'd1;  s_trigger = 1'b1;
    nb = 0;  np = 0;  pe = -1;
    for (int e = 0; e < 280; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_busy) nb++;
      if (s_pulse[0]) begin
        np++;
        pe = e;
      end
      s_trigger = (e + 1 <= 1);
    end
    check("boundary busy cycles", nb, 256);
    check("boundary pulse cycles", np, 1);
    check("boundary pulse edge", pe, 259);
    check("boundary trig_cnt", s_trig_cnt, 1);
    check("boundary miss_cnt", s_miss_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
